// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
package spi_reg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      RD_REQ,
      RD_CAP,
      DATA,
      WR_REQ,
      DONE
   } state_e;

   localparam int         FRAME_BITS        = 16;
   localparam int         HDR_BITS          = 8;
   localparam logic       CMD_WRITE         = 1'b1;
   localparam logic [7:0] READ_INVALID_DATA = 8'h00;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizer plus registered edge detector for one asynchronous SPI pin.
module spi_pin_sync #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   level_q;
   logic                   rise_q;
   logic                   fall_q;

   // Edges are registered alongside the level, so they appear SYNC_STAGES+1 clocks after the pin.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= {SYNC_STAGES{RST_VAL}};
         level_q <= RST_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
         level_q <= sync_q[SYNC_STAGES-1];
         rise_q  <= sync_q[SYNC_STAGES-1] & ~level_q;
         fall_q  <= ~sync_q[SYNC_STAGES-1] & level_q;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into single-cycle register read/write strobes.
module spi_reg_bridge
   import spi_reg_pkg::*;
#(
   parameter int N               = 8,
   parameter int NUM_STATUS_REGS = ((N + 7) / 8 < 1) ? 1 : (N + 7) / 8,
   parameter int ADDR_SIZE       = $clog2(N + NUM_STATUS_REGS),
   parameter int SYNC_STAGES     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 sclk_i,
   input  logic                 cs_n_i,
   input  logic                 mosi_i,
   output logic                 miso_o,
   output logic                 acc_en_o,
   output logic                 wr_en_o,
   output logic [ADDR_SIZE-1:0] addr_o,
   output logic [7:0]           wdata_o,
   input  logic [7:0]           rdata_i,
   output logic                 err_o
);

   localparam int NUM_REGS = N + NUM_STATUS_REGS;

   logic sclk_lvl, sclk_rise, sclk_fall;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, mosi_rise, mosi_fall;
   logic unused_edges;

   // cs_n resets to "low" so a host already selected at reset release never produces a falling edge.
   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(sclk_i),
      .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(cs_n_i),
      .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk_i(clk_i), .rst_i(rst_i), .pin_i(mosi_i),
      .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall));

   assign unused_edges = &{1'b0, sclk_lvl, cs_rise, mosi_rise, mosi_fall};

   state_e               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [7:0]           rx_q, rx_d;
   logic [7:0]           tx_q, tx_d;
   logic                 miso_q, miso_d;
   logic [ADDR_SIZE-1:0] addr_q, addr_d;
   logic [7:0]           wdata_q, wdata_d;
   logic                 err_q, err_d;
   logic                 hdr_wr_q, hdr_wr_d;
   logic [6:0]           hdr_addr_q, hdr_addr_d;
   logic                 extra_q, extra_d;
   logic                 acc_en, wr_en;
   logic [7:0]           rx_shift;

   function automatic logic addr_ok(input logic [6:0] a);
      return ((a >> ADDR_SIZE) == 7'd0) && ({25'd0, a} < 32'(NUM_REGS));
   endfunction

   assign rx_shift = {rx_q[6:0], mosi_lvl};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rx_q       <= '0;
         tx_q       <= '0;
         miso_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         err_q      <= 1'b0;
         hdr_wr_q   <= 1'b0;
         hdr_addr_q <= '0;
         extra_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rx_q       <= rx_d;
         tx_q       <= tx_d;
         miso_q     <= miso_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         err_q      <= err_d;
         hdr_wr_q   <= hdr_wr_d;
         hdr_addr_q <= hdr_addr_d;
         extra_q    <= extra_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rx_d       = rx_q;
      tx_d       = tx_q;
      miso_d     = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = 1'b0;
      hdr_wr_d   = hdr_wr_q;
      hdr_addr_d = hdr_addr_q;
      extra_d    = extra_q;
      acc_en     = 1'b0;
      wr_en      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (cs_fall) begin
               cnt_d   = '0;
               rx_d    = '0;
               tx_d    = '0;
               extra_d = 1'b0;
               state_d = HDR;
            end
         end
         HDR: begin
            if (cs_lvl) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else if (sclk_rise) begin
               rx_d  = rx_shift;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'(HDR_BITS - 1)) begin
                  hdr_wr_d   = rx_shift[7];
                  hdr_addr_d = rx_shift[6:0];
                  if (rx_shift[7] == CMD_WRITE) begin
                     state_d = DATA;
                  end else if (addr_ok(rx_shift[6:0])) begin
                     addr_d  = rx_shift[ADDR_SIZE-1:0];
                     state_d = RD_REQ;
                  end else begin
                     tx_d    = READ_INVALID_DATA;
                     state_d = DATA;
                  end
               end
            end
         end
         RD_REQ: begin
            acc_en  = 1'b1;
            state_d = RD_CAP;
         end
         // The read always completes; a cs_n rise seen meanwhile is honoured here.
         RD_CAP: begin
            tx_d = rdata_i;
            if (cs_lvl) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = DATA;
            end
         end
         DATA: begin
            miso_d = miso_q;
            if (cs_lvl) begin
               miso_d  = 1'b0;
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               if (sclk_fall && (hdr_wr_q != CMD_WRITE)) begin
                  miso_d = tx_q[7];
                  tx_d   = {tx_q[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  rx_d  = rx_shift;
                  cnt_d = cnt_q + 5'd1;
                  if (cnt_q == 5'(FRAME_BITS - 1)) begin
                     if ((hdr_wr_q == CMD_WRITE) && addr_ok(hdr_addr_q)) begin
                        addr_d  = hdr_addr_q[ADDR_SIZE-1:0];
                        wdata_d = rx_shift;
                        state_d = WR_REQ;
                     end else begin
                        state_d = DONE;
                     end
                  end
               end
            end
         end
         WR_REQ: begin
            acc_en  = 1'b1;
            wr_en   = 1'b1;
            state_d = DONE;
         end
         DONE: begin
            if (sclk_rise) begin
               extra_d = 1'b1;
            end
            if (cs_lvl) begin
               err_d   = extra_q | sclk_rise;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign miso_o   = miso_q;
   assign acc_en_o = acc_en;
   assign wr_en_o  = wr_en;
   assign addr_o   = addr_q;
   assign wdata_o  = wdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: SPI host driver, register model and access scoreboard.
module tb_spi_reg_bridge;
   import spi_reg_pkg::*;

   localparam int AW   = 4;
   localparam int W    = 1 + AW + 8;
   localparam int HALF = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          sclk = 1'b0;
   logic          cs_n = 1'b1;
   logic          mosi = 1'b0;
   logic          miso;
   logic          acc_en;
   logic          wr_en;
   logic [AW-1:0] addr;
   logic [7:0]    wdata;
   logic [7:0]    rdata = 8'h00;
   logic          err;

   logic [7:0]    regs [16];
   logic [W-1:0]  exp_q [$];
   int            n_checks = 0;
   int            n_pass = 0;
   int            err_cnt = 0;

   always #5 clk = ~clk;

   spi_reg_bridge dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .sclk_i  (sclk),
      .cs_n_i  (cs_n),
      .mosi_i  (mosi),
      .miso_o  (miso),
      .acc_en_o(acc_en),
      .wr_en_o (wr_en),
      .addr_o  (addr),
      .wdata_o (wdata),
      .rdata_i (rdata),
      .err_o   (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Downstream register block: read data valid one clock after the strobe.
   always @(posedge clk) begin
      if (acc_en && !wr_en) rdata <= regs[addr];
   end

   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] obs;
      if (err) err_cnt++;
      if (acc_en) begin
         if (exp_q.size() == 0) begin
            check("acc_spurious", 32'd1, 32'd0);
         end else begin
            e   = exp_q.pop_front();
            obs = wr_en ? {1'b1, addr, wdata} : {1'b0, addr, 8'h00};
            check("acc", 32'(obs), 32'(e));
         end
      end
   end

   task automatic spi_frame(input logic [31:0] bits, input int nbits, input bit keep_cs,
                            output logic [7:0] rx);
      rx   = 8'h00;
      cs_n = 1'b0;
      for (int i = 0; i < nbits; i++) begin
         mosi = bits[nbits-1-i];
         repeat (HALF) @(negedge clk);
         if (i >= 8 && i < 16) rx = {rx[6:0], miso};
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
      repeat (HALF) @(negedge clk);
      if (!keep_cs) begin
         cs_n = 1'b1;
         mosi = 1'b0;
         repeat (4 * HALF) @(negedge clk);
      end
   endtask

   task automatic run_frame(input string tag, input logic [31:0] bits, input int nbits);
      logic [15:0] word;
      logic        wr;
      logic [6:0]  a;
      logic        ok;
      logic [7:0]  exp_miso;
      logic [7:0]  got;
      int          err0;
      if (nbits >= 16) word = 16'(bits >> (nbits - 16));
      else             word = 16'(bits << (16 - nbits));
      wr       = word[15];
      a        = word[14:8];
      ok       = (a < 7'd9);
      exp_miso = 8'h00;
      if (nbits >= 8 && !wr && ok)  exp_q.push_back({1'b0, a[AW-1:0], 8'h00});
      if (nbits >= 16 && wr && ok)  exp_q.push_back({1'b1, a[AW-1:0], word[7:0]});
      if (nbits >= 16 && !wr && ok) exp_miso = regs[a[AW-1:0]];
      err0 = err_cnt;
      spi_frame(bits, nbits, 1'b0, got);
      if (nbits >= 16) check({tag, "_miso"}, 32'(got), 32'(exp_miso));
      check({tag, "_err"}, 32'(err_cnt - err0), (nbits != 16) ? 32'd1 : 32'd0);
      check({tag, "_acc_left"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_idle"}, 32'(dut.state_q), 32'(IDLE));
   endtask

   initial begin
      logic [7:0]  dummy;
      logic [15:0] rw;
      int          err0;

      for (int i = 0; i < 16; i++) regs[i] = 8'(i * 37 + 5);
      regs[2] = 8'h3C;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_outputs", {19'd0, acc_en, wr_en, addr, wdata, miso, err}, 32'd0);
      check("reset_state", 32'(dut.state_q), 32'(IDLE));
      rst = 1'b0;
      repeat (4) @(negedge clk);

      run_frame("wr83A5", 32'h83A5, 16);
      check("hold_addr_wdata", {20'd0, addr, wdata}, {20'd0, 4'd3, 8'hA5});
      run_frame("rd02", 32'h0200, 16);
      run_frame("wr_abort", 32'h83A5 >> 6, 10);
      run_frame("wr_after_abort", 32'h8511, 16);
      run_frame("rd7F", 32'h7F00, 16);
      run_frame("rd09_invalid", 32'h0900, 16);
      run_frame("wr_long", {16'h8155, 2'b10}, 18);

      // Reset in the middle of a write, cs_n still low on release.
      err0 = err_cnt;
      spi_frame(32'h836, 12, 1'b1, dummy);
      rst = 1'b1;
      #1;
      check("midrst_outputs", {19'd0, acc_en, wr_en, addr, wdata, miso, err}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      spi_frame(32'h6, 4, 1'b0, dummy);
      check("midrst_no_err", 32'(err_cnt - err0), 32'd0);
      check("midrst_no_acc", 32'(exp_q.size()), 32'd0);
      run_frame("after_rst_wr", 32'h8742, 16);
      run_frame("after_rst_rd", 32'h0700, 16);

      for (int k = 0; k < 12; k++) begin
         rw = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 12)), 8'($urandom_range(0, 255))};
         run_frame($sformatf("rand%0d", k), {16'd0, rw}, 16);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
